// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline sequencer: arbitrates data-memory wait, taken-branch flush and
// load-use stall, and drives every stage enable, flush and bubble of the 5-stage core.
module pipeline_stall_ctrl #(
    parameter int unsigned REG_W        = 4,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 15,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] IFID_op1,
    input  logic [REG_W-1:0] IFID_op2,
    input  logic             IFID_use2,
    input  logic [REG_W-1:0] IDEX_rd,
    input  logic             IDEX_MemRead,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IDEX_Write,
    output logic             EXMEM_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             STALL,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_FLUSH   = 2'd1,
        S_MEMWAIT = 2'd2
    } state_t;

    state_t           r_state;
    logic [FC_W-1:0]  r_flush_cnt;
    logic [WC_W-1:0]  r_wait_cnt;
    logic             r_ret_flush;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_stall_count;

    state_t           w_state_nxt;
    logic [FC_W-1:0]  w_flush_cnt_nxt;
    logic [WC_W-1:0]  w_wait_cnt_nxt;
    logic             w_ret_flush_nxt;
    logic             w_timeout_set;
    logic             w_hazard_lu;
    logic             w_memhold;
    logic             w_run_rules;
    logic             w_flush_rules;

    // Register 0 is hard-wired zero, so it can never create a load-use hazard.
    always_comb begin
        w_hazard_lu = IDEX_MemRead && (IDEX_rd != '0) &&
                      ((IFID_op1 == IDEX_rd) || (IFID_use2 && (IFID_op2 == IDEX_rd)));
        w_memhold   = mem_access && !mem_ready;
    end

    // Next-state and enable logic; outputs act in the same cycle the condition is seen.
    always_comb begin
        PCWrite         = 1'b1;
        IFID_Write      = 1'b1;
        IDEX_Write      = 1'b1;
        EXMEM_Write     = 1'b1;
        IFID_Flush      = 1'b0;
        IDEX_Bubble     = 1'b0;
        STALL           = 1'b0;
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_ret_flush_nxt = r_ret_flush;
        w_timeout_set   = 1'b0;
        w_run_rules     = 1'b0;
        w_flush_rules   = 1'b0;

        unique case (r_state)
            S_RUN: begin
                if (w_memhold) begin
                    w_state_nxt     = S_MEMWAIT;
                    w_wait_cnt_nxt  = WC_W'(1);
                    w_ret_flush_nxt = 1'b0;
                end else begin
                    w_run_rules = 1'b1;
                end
            end
            S_FLUSH: begin
                if (w_memhold) begin
                    w_state_nxt     = S_MEMWAIT;
                    w_wait_cnt_nxt  = WC_W'(1);
                    w_ret_flush_nxt = 1'b1;
                end else begin
                    w_flush_rules = 1'b1;
                end
            end
            S_MEMWAIT: begin
                if (w_memhold && (r_wait_cnt < WC_W'(MEM_TIMEOUT))) begin
                    w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
                end else begin
                    // Release cycle: still holding here means the wait timed out.
                    w_timeout_set   = w_memhold;
                    w_wait_cnt_nxt  = '0;
                    w_ret_flush_nxt = 1'b0;
                    w_run_rules     = !r_ret_flush;
                    w_flush_rules   = r_ret_flush;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase

        // Freeze whenever neither the RUN nor FLUSH rules are in charge this cycle.
        if (!w_run_rules && !w_flush_rules) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            EXMEM_Write = 1'b0;
            STALL       = 1'b1;
        end

        if (w_run_rules) begin
            w_state_nxt = S_RUN;
            if (branch_taken) begin
                IFID_Flush  = 1'b1;
                IDEX_Bubble = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    w_state_nxt     = S_FLUSH;
                    w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
                end
            end else if (w_hazard_lu) begin
                PCWrite     = 1'b0;
                IFID_Write  = 1'b0;
                IDEX_Bubble = 1'b1;
                STALL       = 1'b1;
            end
        end

        if (w_flush_rules) begin
            IFID_Flush      = 1'b1;
            IDEX_Bubble     = 1'b1;
            w_flush_cnt_nxt = r_flush_cnt - FC_W'(1);
            w_state_nxt     = (r_flush_cnt == FC_W'(1)) ? S_RUN : S_FLUSH;
        end

        // Reset overrides everything, asynchronously.
        if (!rst) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            EXMEM_Write = 1'b0;
            IFID_Flush  = 1'b0;
            IDEX_Bubble = 1'b0;
            STALL       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_RUN;
            r_flush_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_ret_flush   <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_flush_cnt   <= w_flush_cnt_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_ret_flush   <= w_ret_flush_nxt;
            r_mem_timeout <= r_mem_timeout || w_timeout_set;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= '0;
        end else if (STALL && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign mem_timeout = r_mem_timeout;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed cycles push their expected
// controls, and each is popped and compared once the outputs settle.
module tb_pipeline_stall_ctrl;

    localparam int unsigned REG_W        = 4;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned MEM_TIMEOUT  = 4;
    localparam int unsigned CNT_W        = 4;

    // {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, IFID_Flush, IDEX_Bubble, STALL}
    localparam logic [6:0] C_NORM = 7'b1111_000;
    localparam logic [6:0] C_FRZ  = 7'b0000_001;
    localparam logic [6:0] C_BR   = 7'b1111_110;
    localparam logic [6:0] C_LU   = 7'b0011_011;
    localparam logic [6:0] C_RST  = 7'b0000_000;

    typedef struct packed {
        logic [REG_W-1:0] op1;
        logic [REG_W-1:0] op2;
        logic             use2;
        logic [REG_W-1:0] rd;
        logic             memrd;
        logic             br;
        logic             macc;
        logic             mrdy;
    } stim_t;

    typedef struct packed {
        logic [6:0]       ctl;
        logic             to;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] IFID_op1, IFID_op2, IDEX_rd;
    logic             IFID_use2, IDEX_MemRead, branch_taken, mem_access, mem_ready;
    logic             PCWrite, IFID_Write, IDEX_Write, EXMEM_Write;
    logic             IFID_Flush, IDEX_Bubble, STALL, mem_timeout;
    logic [CNT_W-1:0] stall_count;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    logic [CNT_W-1:0] m_cnt;
    logic             m_to;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .REG_W        (REG_W),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MEM_TIMEOUT  (MEM_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .IFID_op1     (IFID_op1),
        .IFID_op2     (IFID_op2),
        .IFID_use2    (IFID_use2),
        .IDEX_rd      (IDEX_rd),
        .IDEX_MemRead (IDEX_MemRead),
        .branch_taken (branch_taken),
        .mem_access   (mem_access),
        .mem_ready    (mem_ready),
        .PCWrite      (PCWrite),
        .IFID_Write   (IFID_Write),
        .IDEX_Write   (IDEX_Write),
        .EXMEM_Write  (EXMEM_Write),
        .IFID_Flush   (IFID_Flush),
        .IDEX_Bubble  (IDEX_Bubble),
        .STALL        (STALL),
        .mem_timeout  (mem_timeout),
        .stall_count  (stall_count)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic stim_t mk(input logic [REG_W-1:0] op1, input logic [REG_W-1:0] op2,
                                 input logic use2, input logic [REG_W-1:0] rd,
                                 input logic memrd, input logic br,
                                 input logic macc, input logic mrdy);
        stim_t s;
        s.op1 = op1; s.op2 = op2; s.use2 = use2; s.rd = rd;
        s.memrd = memrd; s.br = br; s.macc = macc; s.mrdy = mrdy;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        IFID_op1     = s.op1;
        IFID_op2     = s.op2;
        IFID_use2    = s.use2;
        IDEX_rd      = s.rd;
        IDEX_MemRead = s.memrd;
        branch_taken = s.br;
        mem_access   = s.macc;
        mem_ready    = s.mrdy;
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq({tag, ":sb_empty"}, 16'd0, 16'd1);
            return;
        end
        e = sb_q.pop_front();
        check_eq({tag, ":ctl"}, 16'({PCWrite, IFID_Write, IDEX_Write, EXMEM_Write,
                                     IFID_Flush, IDEX_Bubble, STALL}), 16'(e.ctl));
        check_eq({tag, ":mem_timeout"}, 16'(mem_timeout), 16'(e.to));
        check_eq({tag, ":stall_count"}, 16'(stall_count), 16'(e.cnt));
    endtask

    // One functional cycle: drive at negedge, compare 2ns later, then advance the model.
    task automatic step(input string tag, input stim_t s, input logic [6:0] ctl, input logic set_to);
        exp_t e;
        @(negedge clk);
        apply(s);
        rst = 1'b1;
        e.ctl = ctl; e.to = m_to; e.cnt = m_cnt;
        sb_q.push_back(e);
        #2;
        compare_out(tag);
        if (ctl[0] && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + CNT_W'(1);
        m_to = m_to | set_to;
    endtask

    // Reset asserted mid-cycle, away from the clock edge, to observe the asynchronous drop.
    task automatic rst_step(input string tag, input stim_t s);
        exp_t e;
        @(negedge clk);
        apply(s);
        rst = 1'b0;
        m_cnt = '0;
        m_to  = 1'b0;
        e.ctl = C_RST; e.to = 1'b0; e.cnt = '0;
        sb_q.push_back(e);
        #2;
        compare_out(tag);
    endtask

    initial begin
        stim_t idle;
        stim_t hold;
        idle = '0;
        hold = mk(0, 0, 0, 0, 0, 0, 1, 0);
        rst  = 1'b0;
        apply(idle);
        m_cnt = '0;
        m_to  = 1'b0;

        rst_step("reset", hold);

        // load-use, reg0, use2
        step("t1_lu",       mk(3, 0, 0, 3, 1, 0, 0, 0), C_LU,   1'b0);
        step("t1_after",    mk(3, 0, 0, 3, 0, 0, 0, 0), C_NORM, 1'b0);
        step("t2_reg0",     mk(0, 0, 0, 0, 1, 0, 0, 0), C_NORM, 1'b0);
        step("t2_use2_0",   mk(1, 5, 0, 5, 1, 0, 0, 0), C_NORM, 1'b0);
        step("t2_use2_1",   mk(1, 5, 1, 5, 1, 0, 0, 0), C_LU,   1'b0);
        step("t2_after",    idle,                       C_NORM, 1'b0);

        // branch flush, hazard ignored in FLUSH, branch beats load-use
        step("t3_br",       mk(0, 0, 0, 0, 0, 1, 0, 0), C_BR,   1'b0);
        step("t3_flush",    mk(3, 0, 0, 3, 1, 0, 0, 0), C_BR,   1'b0);
        step("t3_run",      idle,                       C_NORM, 1'b0);
        step("t3_br_lu",    mk(3, 0, 0, 3, 1, 1, 0, 0), C_BR,   1'b0);
        step("t3_br_lu2",   idle,                       C_BR,   1'b0);
        step("t3_run2",     idle,                       C_NORM, 1'b0);

        // memory wait released by ready with a branch
        step("t4_w1",       hold,                       C_FRZ,  1'b0);
        step("t4_w2",       hold,                       C_FRZ,  1'b0);
        step("t4_w3",       hold,                       C_FRZ,  1'b0);
        step("t4_rel_br",   mk(0, 0, 0, 0, 0, 1, 1, 1), C_BR,   1'b0);
        step("t4_flush",    idle,                       C_BR,   1'b0);
        step("t4_run",      idle,                       C_NORM, 1'b0);

        // timeout release and stickiness
        for (int i = 0; i < 4; i++) step("t5_w", hold, C_FRZ, 1'b0);
        step("t5_rel",      hold,                       C_NORM, 1'b1);
        step("t5_sticky",   idle,                       C_NORM, 1'b0);
        step("t5_sticky2",  idle,                       C_NORM, 1'b0);

        // memory wait inside a flush resumes the flush
        step("rf_br",       mk(0, 0, 0, 0, 0, 1, 0, 0), C_BR,   1'b0);
        step("rf_w1",       hold,                       C_FRZ,  1'b0);
        step("rf_w2",       hold,                       C_FRZ,  1'b0);
        step("rf_rel",      mk(0, 0, 0, 0, 0, 0, 1, 1), C_BR,   1'b0);
        step("rf_run",      idle,                       C_NORM, 1'b0);

        // release by mem_access dropping honours load-use
        step("drop_w",      hold,                       C_FRZ,  1'b0);
        step("drop_lu",     mk(7, 0, 0, 7, 1, 0, 0, 0), C_LU,   1'b0);
        step("drop_run",    idle,                       C_NORM, 1'b0);

        // stall_count saturation
        for (int i = 0; i < 3; i++) begin
            step("sat_lu",  mk(2, 0, 0, 2, 1, 0, 0, 0), C_LU,   1'b0);
            step("sat_run", idle,                       C_NORM, 1'b0);
        end

        // reset mid-flush
        step("t6_br",       mk(0, 0, 0, 0, 0, 1, 0, 0), C_BR,   1'b0);
        rst_step("t6_rst_flush", mk(3, 0, 0, 3, 1, 1, 1, 0));
        step("t6_run",      idle,                       C_NORM, 1'b0);

        // reset mid-wait, then a full-length wait proves wait_cnt restarted
        step("t6_w1",       hold,                       C_FRZ,  1'b0);
        step("t6_w2",       hold,                       C_FRZ,  1'b0);
        rst_step("t6_rst_wait", hold);
        for (int i = 0; i < 4; i++) step("t6_fw", hold, C_FRZ, 1'b0);
        step("t6_rel",      hold,                       C_NORM, 1'b1);
        step("t6_to",       idle,                       C_NORM, 1'b0);

        check_eq("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
